usr_param: RTL and testbench

//  WIDTH-bit universal shift register with eight register modes (hold, shift L/R, load,

---
 rtl/usr_pkg.sv | 23 ++
 rtl/usr_next_val.sv | 29 ++
 rtl/usr_param.sv | 105 ++++++++++
 tb/tb_usr_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: register ops, FSM states, burst direction.
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD = 3'b000,
        USR_SHL  = 3'b001,
        USR_SHR  = 3'b010,
        USR_LOAD = 3'b011,
        USR_ROL  = 3'b100,
        USR_ROR  = 3'b101,
        USR_ASR  = 3'b110,
        USR_CLR  = 3'b111
    } usr_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } usr_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-value function of the shift register, shared by mode ops and bursts.
module usr_next_val
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_po,
    input  logic [WIDTH-1:0] i_pi,
    input  logic             i_si,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_next
);

    always_comb begin
        o_next = i_po;
        unique case (i_op)
            USR_HOLD: o_next = i_po;
            USR_SHL:  o_next = {i_po[WIDTH-2:0], i_si};
            USR_SHR:  o_next = {i_si, i_po[WIDTH-1:1]};
            USR_LOAD: o_next = i_pi;
            USR_ROL:  o_next = {i_po[WIDTH-2:0], i_po[WIDTH-1]};
            USR_ROR:  o_next = {i_po[0], i_po[WIDTH-1:1]};
            USR_ASR:  o_next = {i_po[WIDTH-1], i_po[WIDTH-1:1]};
            USR_CLR:  o_next = '0;
            default:  o_next = i_po;
        endcase
    end

endmodule

// File: rtl/usr_param.sv
// Universal shift register with eight register ops and an autonomous WIDTH-shift burst engine.
module usr_param
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pi,
    input  logic             si,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] po,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    usr_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] r_po, w_po_nxt;
    logic [WIDTH-1:0] w_next_po;
    logic [2:0]       w_op;
    logic             w_left;

    // During a burst the op is forced to a plain shift; start suppresses the mode op.
    always_comb begin
        w_op = mode;
        if (r_state == ST_SHIFT) begin
            w_op = (r_dir == DIR_RIGHT) ? USR_SHR : USR_SHL;
        end else if (start) begin
            w_op = USR_HOLD;
        end
    end

    usr_next_val #(
        .WIDTH (WIDTH)
    ) u_next_val (
        .i_po   (r_po),
        .i_pi   (pi),
        .i_si   (si),
        .i_op   (w_op),
        .o_next (w_next_po)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_po_nxt    = r_po;
        w_done_nxt  = 1'b0;
        if (en) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_dir_nxt   = dir;
                        w_cnt_nxt   = CNT_W'(WIDTH);
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_po_nxt = w_next_po;
                    end
                end
                ST_SHIFT: begin
                    w_po_nxt  = w_next_po;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_LEFT;
            r_done  <= 1'b0;
            r_po    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
            r_po    <= w_po_nxt;
        end
    end

    assign w_left = (r_state == ST_SHIFT) ? (r_dir == DIR_LEFT)
                                          : (mode == USR_SHL || mode == USR_ROL);
    assign so     = w_left ? r_po[WIDTH-1] : r_po[0];
    assign po     = r_po;
    assign busy   = (r_state == ST_SHIFT);
    assign done   = r_done;

endmodule

// File: tb/tb_usr_param.sv
// Directed self-checking bench for usr_param at WIDTH=8.
module tb_usr_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] pi;
    logic       si;
    logic       start;
    logic       dir;
    logic [7:0] po;
    logic       so;
    logic       busy;
    logic       done;

    int n_chk;
    int n_fail;

    usr_param #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .pi    (pi),
        .si    (si),
        .start (start),
        .dir   (dir),
        .po    (po),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        mode = 3'b011;
        pi   = val;
        step();
        mode = 3'b000;
    endtask

    logic [7:0] so_exp;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        en     = 1'b0;
        mode   = 3'b000;
        pi     = 8'h00;
        si     = 1'b0;
        start  = 1'b0;
        dir    = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_po", po, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        step();
        rst = 1'b0;
        en  = 1'b1;

        // Mode ops
        load(8'hA5);
        chk("load_a5", po, 8'hA5);
        mode = 3'b001;
        si   = 1'b1;
        #1;
        chk("shl_so_pre", {7'b0, so}, 8'h01);
        step();
        chk("shl", po, 8'h4B);
        load(8'hA5);
        mode = 3'b101;
        step();
        chk("ror", po, 8'hD2);
        load(8'h85);
        mode = 3'b110;
        step();
        chk("asr", po, 8'hC2);
        mode = 3'b111;
        step();
        chk("clr", po, 8'h00);
        load(8'h81);
        mode = 3'b100;
        #1;
        chk("rol_so_pre", {7'b0, so}, 8'h01);
        step();
        chk("rol", po, 8'h03);
        mode = 3'b010;
        si   = 1'b1;
        #1;
        chk("shr_so_pre", {7'b0, so}, 8'h01);
        step();
        chk("shr", po, 8'h81);
        mode = 3'b000;
        step();
        chk("hold", po, 8'h81);
        en   = 1'b0;
        mode = 3'b111;
        step();
        chk("en0_freeze", po, 8'h81);
        en   = 1'b1;
        mode = 3'b000;

        // Left burst from C3
        load(8'hC3);
        si    = 1'b0;
        dir   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b1_start_po", po, 8'hC3);
        chk("b1_busy", {7'b0, busy}, 8'h01);
        so_exp = 8'b1100_0011;
        for (int i = 0; i < 8; i++) begin
            chk("b1_so", {7'b0, so}, {7'b0, so_exp[7-i]});
            chk("b1_busy_run", {7'b0, busy}, 8'h01);
            step();
        end
        chk("b1_end_busy", {7'b0, busy}, 8'h00);
        chk("b1_done", {7'b0, done}, 8'h01);
        chk("b1_po", po, 8'h00);
        step();
        chk("b1_done_clr", {7'b0, done}, 8'h00);

        // Same burst with an en=0 stall and start/load requests while busy
        load(8'hC3);
        start = 1'b1;
        step();
        mode = 3'b011;
        pi   = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                en = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("b2_frozen_po", po, 8'h30);
                    chk("b2_frozen_busy", {7'b0, busy}, 8'h01);
                    chk("b2_frozen_done", {7'b0, done}, 8'h00);
                    start = ~start;
                end
                en = 1'b1;
            end
            chk("b2_so", {7'b0, so}, {7'b0, so_exp[7-i]});
            if (i == 7) begin
                start = 1'b0;
                mode  = 3'b000;
            end
            step();
        end
        chk("b2_done", {7'b0, done}, 8'h01);
        chk("b2_po", po, 8'h00);
        step();

        // Reset mid-burst, then a full right burst
        load(8'hC3);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("b3_mid_po", po, 8'h30);
        #2 rst = 1'b1;
        #1;
        chk("b3_rst_po", po, 8'h00);
        chk("b3_rst_busy", {7'b0, busy}, 8'h00);
        step();
        rst = 1'b0;
        step();
        chk("b3_no_done", {7'b0, done}, 8'h00);
        load(8'h96);
        si    = 1'b1;
        dir   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        dir   = 1'b0;
        so_exp = 8'h96;
        for (int i = 0; i < 8; i++) begin
            chk("b4_so", {7'b0, so}, {7'b0, so_exp[i]});
            step();
        end
        chk("b4_done", {7'b0, done}, 8'h01);
        chk("b4_po", po, 8'hFF);
        mode = 3'b011;
        pi   = 8'h5A;
        step();
        chk("done_cycle_load", po, 8'h5A);
        chk("done_clr", {7'b0, done}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
